// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath: status inputs plus every
// control strobe the sequencer drives.
interface control_sequencer_if;
    logic       stop;
    logic [4:0] opcode;
    logic       CON_FF;

    logic       run;
    logic       Clear;
    logic [4:0] alu_op;
    logic       Gra, Grb, Grc, Rin, Rout, BAout;
    logic       PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
    logic       Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout;
    logic       Cout, CONin, InPortout, OutPortin;

    modport master (
        input  stop, opcode, CON_FF,
        output run, Clear, alu_op, Gra, Grb, Grc, Rin, Rout, BAout,
               PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
               Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout,
               Cout, CONin, InPortout, OutPortin
    );

    modport slave (
        output stop, opcode, CON_FF,
        input  run, Clear, alu_op, Gra, Grb, Grc, Rin, Rout, BAout,
               PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
               Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout,
               Cout, CONin, InPortout, OutPortin
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control FSM for the mini CPU; one control step per clock,
// strobes decoded from the current step and the instruction class.
module control_sequencer #(
    parameter logic [4:0] OP_ADD = 5'b00011
) (
    input logic           clock,
    input logic           reset,
    control_sequencer_if.master bus
);
    localparam int unsigned OP_W = 5;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_LD, C_ST, C_LDI, C_MUL, C_NEG, C_BR,
        C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } cls_t;

    state_t          state_q, state_d, boundary;
    logic [OP_W-1:0] op_q, eff_op;
    cls_t            cls;

    function automatic cls_t classify(input logic [OP_W-1:0] op);
        cls_t c;
        c = C_NOP;
        if (op >= 5'd3 && op <= 5'd11)       c = C_ALU;
        else if (op >= 5'd12 && op <= 5'd14) c = C_IMM;
        else begin
            case (op)
                5'b00000:          c = C_LD;
                5'b00001:          c = C_LDI;
                5'b00010:          c = C_ST;
                5'b01111, 5'b10000: c = C_MUL;
                5'b10001, 5'b10010: c = C_NEG;
                5'b10011:          c = C_BR;
                5'b10100:          c = C_JR;
                5'b10110:          c = C_IN;
                5'b10111:          c = C_OUT;
                5'b11000:          c = C_MFHI;
                5'b11001:          c = C_MFLO;
                5'b11011:          c = C_HALT;
                default:           c = C_NOP;
            endcase
        end
        return c;
    endfunction

    // The IR only holds the new opcode from T3 on, so T3 decodes it live and latches it.
    assign eff_op   = (state_q == S_T3) ? bus.opcode : op_q;
    assign cls      = classify(eff_op);
    assign boundary = bus.stop ? S_HALT : S_T0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RESET;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_T3) op_q <= bus.opcode;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.run       = (state_q != S_RESET) && (state_q != S_HALT);
        bus.Clear     = (state_q == S_RESET);
        bus.alu_op    = '0;
        bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
        bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
        bus.PCout = 1'b0; bus.PCin = 1'b0; bus.IncPC = 1'b0; bus.MARin = 1'b0;
        bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
        bus.IRin = 1'b0; bus.Yin = 1'b0; bus.Zin = 1'b0; bus.Zhighout = 1'b0;
        bus.Zlowout = 1'b0; bus.HIin = 1'b0; bus.LOin = 1'b0; bus.HIout = 1'b0;
        bus.LOout = 1'b0; bus.Cout = 1'b0; bus.CONin = 1'b0;
        bus.InPortout = 1'b0; bus.OutPortin = 1'b0;

        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                state_d = S_T4;
                case (cls)
                    C_ALU, C_IMM: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    C_LD, C_ST, C_LDI: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                    C_MUL: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    C_NEG: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = eff_op;
                    end
                    C_BR: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
                    C_JR: begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; state_d = boundary;
                    end
                    C_IN: begin
                        bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; state_d = boundary;
                    end
                    C_OUT: begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1; state_d = boundary;
                    end
                    C_MFHI: begin
                        bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; state_d = boundary;
                    end
                    C_MFLO: begin
                        bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; state_d = boundary;
                    end
                    C_HALT:  state_d = S_HALT;
                    default: state_d = boundary;
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                case (cls)
                    C_ALU: begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = eff_op;
                    end
                    C_IMM: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = eff_op; end
                    C_LD, C_ST, C_LDI: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = OP_ADD; end
                    C_MUL: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = eff_op;
                    end
                    C_NEG: begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; state_d = boundary;
                    end
                    C_BR:    begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
                    default: state_d = boundary;
                endcase
            end
            S_T5: begin
                state_d = S_T6;
                case (cls)
                    C_ALU, C_IMM, C_LDI: begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; state_d = boundary;
                    end
                    C_LD, C_ST: begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
                    C_MUL:      begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
                    C_BR:       begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = OP_ADD; end
                    default:    state_d = boundary;
                endcase
            end
            S_T6: begin
                state_d = S_T7;
                case (cls)
                    C_LD: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                    C_ST: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
                    C_MUL: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; state_d = boundary; end
                    // Branch commit is the one strobe that follows an input directly.
                    C_BR: begin bus.Zlowout = 1'b1; bus.PCin = bus.CON_FF; state_d = boundary; end
                    default: state_d = boundary;
                endcase
            end
            S_T7: begin
                state_d = boundary;
                case (cls)
                    C_LD:    begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    C_ST:    bus.Write = 1'b1;
                    default: ;
                endcase
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues the expected strobe word
// for each cycle, a negedge monitor pops and compares it against the DUT outputs.
module tb_control_sequencer;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    control_sequencer_if ifc ();

    control_sequencer #(.OP_ADD(5'b00011)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (ifc)
    );

    localparam logic [33:0] ONE       = 34'h1;
    localparam logic [33:0] OUTPORTIN = ONE << 0;
    localparam logic [33:0] INPORTOUT = ONE << 1;
    localparam logic [33:0] CONIN     = ONE << 2;
    localparam logic [33:0] COUT      = ONE << 3;
    localparam logic [33:0] LOOUT     = ONE << 4;
    localparam logic [33:0] HIOUT     = ONE << 5;
    localparam logic [33:0] LOIN      = ONE << 6;
    localparam logic [33:0] HIIN      = ONE << 7;
    localparam logic [33:0] ZLOWOUT   = ONE << 8;
    localparam logic [33:0] ZHIGHOUT  = ONE << 9;
    localparam logic [33:0] ZIN       = ONE << 10;
    localparam logic [33:0] YIN       = ONE << 11;
    localparam logic [33:0] IRIN      = ONE << 12;
    localparam logic [33:0] WRITE     = ONE << 13;
    localparam logic [33:0] READ      = ONE << 14;
    localparam logic [33:0] MDROUT    = ONE << 15;
    localparam logic [33:0] MDRIN     = ONE << 16;
    localparam logic [33:0] MARIN     = ONE << 17;
    localparam logic [33:0] INCPC     = ONE << 18;
    localparam logic [33:0] PCIN      = ONE << 19;
    localparam logic [33:0] PCOUT     = ONE << 20;
    localparam logic [33:0] BAOUT     = ONE << 21;
    localparam logic [33:0] ROUT      = ONE << 22;
    localparam logic [33:0] RIN       = ONE << 23;
    localparam logic [33:0] GRC       = ONE << 24;
    localparam logic [33:0] GRB       = ONE << 25;
    localparam logic [33:0] GRA       = ONE << 26;
    localparam logic [33:0] CLEAR     = ONE << 32;
    localparam logic [33:0] RUN       = ONE << 33;

    function automatic logic [33:0] alu(input logic [4:0] op);
        return 34'(op) << 27;
    endfunction

    logic [33:0] obs;
    assign obs = {ifc.run, ifc.Clear, ifc.alu_op, ifc.Gra, ifc.Grb, ifc.Grc, ifc.Rin,
                  ifc.Rout, ifc.BAout, ifc.PCout, ifc.PCin, ifc.IncPC, ifc.MARin,
                  ifc.MDRin, ifc.MDRout, ifc.Read, ifc.Write, ifc.IRin, ifc.Yin, ifc.Zin,
                  ifc.Zhighout, ifc.Zlowout, ifc.HIin, ifc.LOin, ifc.HIout, ifc.LOout,
                  ifc.Cout, ifc.CONin, ifc.InPortout, ifc.OutPortin};

    logic [33:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [33:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", t, obs, e);
            end
        end
    end

    task automatic cyc(input logic [33:0] m, input string tag);
        exp_q.push_back(m);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
    endtask

    task automatic ex(input logic [33:0] m, input string tag);
        cyc(RUN | m, tag);
    endtask

    // One full instruction from T0; abort asserts reset during ld T5.
    task automatic instr(input logic [4:0] op, input logic con, input logic stp,
                         input bit abort, input string nm);
        logic [33:0] t3;
        ifc.opcode = op;
        ifc.CON_FF = con;
        ifc.stop   = stp;
        ex(PCOUT | MARIN | INCPC | ZIN, {nm, " T0"});
        ex(ZLOWOUT | PCIN | READ | MDRIN, {nm, " T1"});
        ex(MDROUT | IRIN, {nm, " T2"});
        t3 = '0;
        if (op inside {[5'd3:5'd14]})            t3 = GRB | ROUT | YIN;
        else if (op inside {5'd0, 5'd1, 5'd2})   t3 = GRB | BAOUT | YIN;
        else if (op inside {5'd15, 5'd16})       t3 = GRA | ROUT | YIN;
        else if (op inside {5'd17, 5'd18})       t3 = GRB | ROUT | ZIN | alu(op);
        else if (op == 5'd19)                    t3 = GRA | ROUT | CONIN;
        else if (op == 5'd20)                    t3 = GRA | ROUT | PCIN;
        else if (op == 5'd22)                    t3 = INPORTOUT | GRA | RIN;
        else if (op == 5'd23)                    t3 = GRA | ROUT | OUTPORTIN;
        else if (op == 5'd24)                    t3 = HIOUT | GRA | RIN;
        else if (op == 5'd25)                    t3 = LOOUT | GRA | RIN;
        ex(t3, {nm, " T3"});
        ifc.opcode = ~op;
        if (op inside {[5'd3:5'd11]}) begin
            ex(GRC | ROUT | ZIN | alu(op), {nm, " T4"});
            ex(ZLOWOUT | GRA | RIN, {nm, " T5"});
        end else if (op inside {[5'd12:5'd14]}) begin
            ex(COUT | ZIN | alu(op), {nm, " T4"});
            ex(ZLOWOUT | GRA | RIN, {nm, " T5"});
        end else if (op == 5'd1) begin
            ex(COUT | ZIN | alu(5'b00011), {nm, " T4"});
            ex(ZLOWOUT | GRA | RIN, {nm, " T5"});
        end else if (op inside {5'd0, 5'd2}) begin
            ex(COUT | ZIN | alu(5'b00011), {nm, " T4"});
            if (abort) begin
                reset = 1'b1;
                ex(ZLOWOUT | MARIN, {nm, " T5"});
                reset = 1'b0;
                return;
            end
            ex(ZLOWOUT | MARIN, {nm, " T5"});
            if (op == 5'd0) begin
                ex(READ | MDRIN, {nm, " T6"});
                ex(MDROUT | GRA | RIN, {nm, " T7"});
            end else begin
                ex(GRA | ROUT | MDRIN, {nm, " T6"});
                ex(WRITE, {nm, " T7"});
            end
        end else if (op inside {5'd15, 5'd16}) begin
            ex(GRB | ROUT | ZIN | alu(op), {nm, " T4"});
            ex(ZLOWOUT | LOIN, {nm, " T5"});
            ex(ZHIGHOUT | HIIN, {nm, " T6"});
        end else if (op inside {5'd17, 5'd18}) begin
            ex(ZLOWOUT | GRA | RIN, {nm, " T4"});
        end else if (op == 5'd19) begin
            ex(PCOUT | YIN, {nm, " T4"});
            ex(COUT | ZIN | alu(5'b00011), {nm, " T5"});
            ex(ZLOWOUT | (con ? PCIN : 34'h0), {nm, " T6"});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        ifc.stop   = 1'b0;
        ifc.opcode = 5'b11010;
        ifc.CON_FF = 1'b0;
        @(posedge clock);
        #1;
        cyc(CLEAR, "reset cycle 1");
        reset = 1'b0;
        cyc(CLEAR, "reset cycle 2");

        instr(5'b00011, 1'b0, 1'b0, 1'b0, "add");
        instr(5'b00010, 1'b0, 1'b0, 1'b0, "st");
        instr(5'b00000, 1'b0, 1'b0, 1'b0, "ld");
        instr(5'b00111, 1'b0, 1'b0, 1'b0, "shr");
        instr(5'b01100, 1'b0, 1'b0, 1'b0, "addi");
        instr(5'b01110, 1'b0, 1'b0, 1'b0, "ori");
        instr(5'b00001, 1'b0, 1'b0, 1'b0, "ldi");
        instr(5'b10001, 1'b0, 1'b0, 1'b0, "neg");
        instr(5'b10010, 1'b0, 1'b0, 1'b0, "not");
        instr(5'b10011, 1'b0, 1'b0, 1'b0, "br nottaken");
        instr(5'b10011, 1'b1, 1'b0, 1'b0, "br taken");
        instr(5'b10100, 1'b0, 1'b0, 1'b0, "jr");
        instr(5'b10110, 1'b0, 1'b0, 1'b0, "in");
        instr(5'b10111, 1'b0, 1'b0, 1'b0, "out");
        instr(5'b11000, 1'b0, 1'b0, 1'b0, "mfhi");
        instr(5'b11001, 1'b0, 1'b0, 1'b0, "mflo");
        instr(5'b11010, 1'b0, 1'b0, 1'b0, "nop");
        instr(5'b10101, 1'b0, 1'b0, 1'b0, "undef 10101");
        instr(5'b11111, 1'b0, 1'b0, 1'b0, "undef 11111");

        instr(5'b00000, 1'b0, 1'b0, 1'b1, "ld aborted");
        cyc(CLEAR, "reset after ld T5");

        instr(5'b01111, 1'b0, 1'b1, 1'b0, "mul with stop");
        ifc.stop = 1'b0;
        cyc('0, "halt 1");
        cyc('0, "halt 2");
        reset = 1'b1;
        cyc('0, "halt 3");
        reset = 1'b0;
        cyc(CLEAR, "reset after halt");

        instr(5'b10000, 1'b0, 1'b0, 1'b0, "div");
        instr(5'b11011, 1'b0, 1'b0, 1'b0, "halt op");
        cyc('0, "halt op state 1");
        cyc('0, "halt op state 2");

        @(negedge clock);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
